ddr3_inport_responder: RTL and testbench
========================================

DDR3_INPORT_RESPONDER -- requirements
Module: ddr3_inport_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, log2 of number of 128-bit lines stored.
REQ-002 SHALL have parameter ACK_LATENCY, default 4, cycles from accepting edge to ack (legal 1..255).
REQ-003 SHALL have parameter REFRESH_PERIOD, default 780, cycles between refresh stalls (0 = refresh disabled).
REQ-004 SHALL have parameter REFRESH_CYCLES, default 16, accept-blocked cycles per refresh (legal 1..255).
REQ-005 SHALL have port clk_i  input  1  the single clock; all flops on rising edge.
REQ-006 SHALL have port rst_i  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port inport_wr_i  input  16  per-byte write strobes; non-zero means write request.
REQ-008 SHALL have port inport_rd_i  input  1  read request.
REQ-009 SHALL have port inport_addr_i  input  32  byte address; bits [3:0] ignored.
REQ-010 SHALL have port inport_write_data_i  input  128  write data; byte i = bits [8i+7:8i].
REQ-011 SHALL have port inport_req_id_i  input  16  request tag.
REQ-012 SHALL have port inport_accept_o  output  1  request taken on edge where request valid and accept high.
REQ-013 SHALL have port inport_ack_o  output  1  one-cycle response strobe.
REQ-014 SHALL have port inport_error_o  output  1  response is an error; valid with ack.
REQ-015 SHALL have port inport_resp_id_o  output  16  tag of the responding request.
REQ-016 SHALL have port inport_read_data_o  output  128  read data; valid with ack.

Function
REQ-017 SHALL implement FSM states IDLE, BUSY, RESP, REFRESH; at most one request outstanding.
REQ-018 SHALL drive inport_accept_o = (state==IDLE) && !refresh_due, from registered state only.
REQ-019 SHALL, on accepting edge, latch req_id, error flag and line index addr[ADDR_W+3:4], then enter BUSY (or RESP if ACK_LATENCY==1).
REQ-020 SHALL flag error when wr!=0 and rd==1 simultaneously, or addr[31:ADDR_W+4]!=0; error requests do not modify memory.
REQ-021 SHALL perform the masked write at the accepting edge; unmasked bytes keep old contents.
REQ-022 SHALL assert inport_ack_o for exactly one cycle, exactly ACK_LATENCY cycles after the accepting edge, in state RESP, then return to IDLE.
REQ-023 SHALL present line contents on inport_read_data_o with a read ack; for write acks read_data is zero; error acks return zero data.
REQ-024 SHALL hold inport_resp_id_o, inport_read_data_o stable outside ack; inport_error_o is 0 when ack is 0.
REQ-025 SHALL run a free-running refresh counter wrapping at REFRESH_PERIOD-1; on wrap set refresh_due, cleared when REFRESH completes.
REQ-026 SHALL move IDLE->REFRESH when refresh_due; stay REFRESH_CYCLES cycles with accept low; then IDLE.
REQ-027 SHALL give refresh priority over a request present in the same IDLE cycle (request not accepted).
REQ-028 SHALL defer refresh while BUSY/RESP; a second wrap while due remains pending does not queue an extra refresh.
REQ-029 SHALL treat request inputs as don't-care when accept is low; a held request is accepted once, on first accept cycle.

Reset
REQ-030 SHALL, on rst_i, force state IDLE, refresh counter 0, refresh_due 0, and all outputs 0 except accept (1 after reset release, same cycle combinationally).
REQ-031 SHALL abort any outstanding request on reset mid-operation: no ack is ever issued for it.
REQ-032 SHALL NOT reset memory contents.

Structure
REQ-033 SHALL take FSM state encodings and parameter defaults from a shared header included by this block and its bench.
REQ-034 SHALL place storage in one sub-module ddr3_inport_ram_mem: 2^ADDR_W x 128-bit, 16 byte-enables, synchronous write, asynchronous read.

Verification
REQ-035 Write addr 0 data ffeeddccbbaa99887766554433221100 mask FFFF, read 0 -> same data, ack 4 cycles after accept, error 0.
REQ-036 Write 16 mask FFFF then write 16 data 0 mask 000F, read 16 -> beaffeadd0d0600d5555AAAA00000000 with low 4 bytes 00.
REQ-037 wr=FFFF and rd=1 together, id 0x0007 -> ack with error 1, resp_id 0x0007, memory unchanged; addr 0x0001_0000 (ADDR_W=8) -> error 1.
REQ-038 REFRESH_PERIOD=50: request held on refresh wrap -> accept low 16 cycles, then accepted, resp_id matches.
REQ-039 rst_i asserted 2 cycles after accept -> no ack ever; next request after release acks normally.
REQ-040 Back-to-back requests ids 1,2,3 held continuously -> three acks in order, each accept exactly one cycle.

Source files
------------

// File: rtl/ddr3_inport_responder_pkg.sv
// rtl/ddr3_inport_responder_pkg.sv - shared FSM encoding and parameter defaults for the DDR3 inport responder
package ddr3_inport_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY    = 2'd1,
    ST_RESP    = 2'd2,
    ST_REFRESH = 2'd3
  } state_e;

  localparam int DEF_ADDR_W         = 8;
  localparam int DEF_ACK_LATENCY    = 4;
  localparam int DEF_REFRESH_PERIOD = 780;
  localparam int DEF_REFRESH_CYCLES = 16;

  localparam int LINE_W  = 128;
  localparam int LINE_BE = LINE_W / 8;

endpackage

// File: rtl/ddr3_inport_ram_mem.sv
// rtl/ddr3_inport_ram_mem.sv - 128-bit line store with byte enables, synchronous write, asynchronous read
module ddr3_inport_ram_mem
  import ddr3_inport_responder_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk_i,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [LINE_BE-1:0] wr_be_i,
  input  logic [LINE_W-1:0] wr_data_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [LINE_W-1:0] rd_data_o
);

  logic [LINE_W-1:0] mem_q [2**ADDR_W];

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      for (int i = 0; i < LINE_BE; i++) begin
        if (wr_be_i[i]) begin
          mem_q[wr_addr_i][8*i +: 8] <= wr_data_i[8*i +: 8];
        end
      end
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/ddr3_inport_responder.sv
// rtl/ddr3_inport_responder.sv - single-outstanding request responder with fixed ack latency and periodic refresh stalls
module ddr3_inport_responder
  import ddr3_inport_responder_pkg::*;
#(
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int ACK_LATENCY    = DEF_ACK_LATENCY,
  parameter int REFRESH_PERIOD = DEF_REFRESH_PERIOD,
  parameter int REFRESH_CYCLES = DEF_REFRESH_CYCLES
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [LINE_BE-1:0]  inport_wr_i,
  input  logic                inport_rd_i,
  input  logic [31:0]         inport_addr_i,
  input  logic [LINE_W-1:0]   inport_write_data_i,
  input  logic [15:0]         inport_req_id_i,
  output logic                inport_accept_o,
  output logic                inport_ack_o,
  output logic                inport_error_o,
  output logic [15:0]         inport_resp_id_o,
  output logic [LINE_W-1:0]   inport_read_data_o
);

  state_e            state_q, state_d;
  logic [7:0]        lat_cnt_q, lat_cnt_d;
  logic [7:0]        ref_cyc_q, ref_cyc_d;
  logic [31:0]       ref_cnt_q, ref_cnt_d;
  logic              ref_due_q, ref_due_d;
  logic [15:0]       req_id_q, req_id_d;
  logic              req_err_q, req_err_d;
  logic              req_rd_q, req_rd_d;
  logic [ADDR_W-1:0] line_q, line_d;
  logic              ack_q, ack_d;
  logic              err_q, err_d;
  logic [15:0]       resp_id_q, resp_id_d;
  logic [LINE_W-1:0] rdata_q, rdata_d;

  logic              req_valid, req_err, take, mem_we, ref_wrap, ref_done, load_resp;
  logic              src_rd, src_err;
  logic [15:0]       src_id;
  logic [ADDR_W-1:0] req_line, mem_raddr;
  logic [LINE_W-1:0] mem_rdata;

  assign inport_accept_o    = (state_q == ST_IDLE) && !ref_due_q;
  assign inport_ack_o       = ack_q;
  assign inport_error_o     = err_q;
  assign inport_resp_id_o   = resp_id_q;
  assign inport_read_data_o = rdata_q;

  assign req_valid = (|inport_wr_i) || inport_rd_i;
  assign req_err   = ((|inport_wr_i) && inport_rd_i) || ((inport_addr_i >> (ADDR_W + 4)) != 32'd0);
  assign req_line  = inport_addr_i[ADDR_W+3:4];
  assign take      = inport_accept_o && req_valid;
  assign mem_we    = take && !req_err && (|inport_wr_i);
  assign ref_wrap  = (REFRESH_PERIOD != 0) && (ref_cnt_q == 32'(REFRESH_PERIOD - 1));

  // With ACK_LATENCY==1 the response is built straight from the inputs on the accepting edge.
  assign src_rd    = (state_q == ST_IDLE) ? inport_rd_i     : req_rd_q;
  assign src_err   = (state_q == ST_IDLE) ? req_err         : req_err_q;
  assign src_id    = (state_q == ST_IDLE) ? inport_req_id_i : req_id_q;
  assign mem_raddr = (state_q == ST_IDLE) ? req_line        : line_q;

  ddr3_inport_ram_mem #(.ADDR_W(ADDR_W)) u_mem (
    .clk_i     (clk_i),
    .wr_en_i   (mem_we),
    .wr_addr_i (req_line),
    .wr_be_i   (inport_wr_i),
    .wr_data_i (inport_write_data_i),
    .rd_addr_i (mem_raddr),
    .rd_data_o (mem_rdata)
  );

  always_comb begin
    state_d   = state_q;
    lat_cnt_d = lat_cnt_q;
    ref_cyc_d = ref_cyc_q;
    req_id_d  = req_id_q;
    req_err_d = req_err_q;
    req_rd_d  = req_rd_q;
    line_d    = line_q;
    ack_d     = 1'b0;
    err_d     = 1'b0;
    resp_id_d = resp_id_q;
    rdata_d   = rdata_q;
    ref_done  = 1'b0;
    load_resp = 1'b0;
    ref_cnt_d = (REFRESH_PERIOD == 0 || ref_wrap) ? 32'd0 : ref_cnt_q + 32'd1;

    case (state_q)
      ST_IDLE: begin
        // The IDLE cycle that sees refresh_due already counts as the first stall cycle.
        if (ref_due_q) begin
          if (REFRESH_CYCLES == 1) begin
            ref_done = 1'b1;
          end else begin
            state_d   = ST_REFRESH;
            ref_cyc_d = 8'd1;
          end
        end else if (req_valid) begin
          req_id_d  = inport_req_id_i;
          req_err_d = req_err;
          req_rd_d  = inport_rd_i;
          line_d    = req_line;
          if (ACK_LATENCY == 1) begin
            load_resp = 1'b1;
            state_d   = ST_RESP;
          end else begin
            lat_cnt_d = 8'd1;
            state_d   = ST_BUSY;
          end
        end
      end
      ST_BUSY: begin
        if (lat_cnt_q == 8'(ACK_LATENCY - 1)) begin
          load_resp = 1'b1;
          state_d   = ST_RESP;
        end else begin
          lat_cnt_d = lat_cnt_q + 8'd1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      ST_REFRESH: begin
        if (ref_cyc_q == 8'(REFRESH_CYCLES - 1)) begin
          ref_done = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          ref_cyc_d = ref_cyc_q + 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (load_resp) begin
      ack_d     = 1'b1;
      err_d     = src_err;
      resp_id_d = src_id;
      rdata_d   = (src_rd && !src_err) ? mem_rdata : '0;
    end

    ref_due_d = (ref_due_q && !ref_done) || ref_wrap;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      lat_cnt_q <= '0;
      ref_cyc_q <= '0;
      ref_cnt_q <= '0;
      ref_due_q <= 1'b0;
      req_id_q  <= '0;
      req_err_q <= 1'b0;
      req_rd_q  <= 1'b0;
      line_q    <= '0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      resp_id_q <= '0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      lat_cnt_q <= lat_cnt_d;
      ref_cyc_q <= ref_cyc_d;
      ref_cnt_q <= ref_cnt_d;
      ref_due_q <= ref_due_d;
      req_id_q  <= req_id_d;
      req_err_q <= req_err_d;
      req_rd_q  <= req_rd_d;
      line_q    <= line_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      resp_id_q <= resp_id_d;
      rdata_q   <= rdata_d;
    end
  end

endmodule

// File: tb/tb_ddr3_inport_responder.sv
// tb/tb_ddr3_inport_responder.sv - randomized bench with a cycle-window reference model for the DDR3 inport responder
module tb_ddr3_inport_responder;
  import ddr3_inport_responder_pkg::*;

  localparam int AW  = DEF_ADDR_W;
  localparam int LAT = DEF_ACK_LATENCY;
  localparam int RP  = 50;
  localparam int RC  = DEF_REFRESH_CYCLES;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b1;
  logic [15:0]  inport_wr_i = '0;
  logic         inport_rd_i = 1'b0;
  logic [31:0]  inport_addr_i = '0;
  logic [127:0] inport_write_data_i = '0;
  logic [15:0]  inport_req_id_i = '0;
  logic         inport_accept_o, inport_ack_o, inport_error_o;
  logic [15:0]  inport_resp_id_o;
  logic [127:0] inport_read_data_o;

  always #5 clk_i = ~clk_i;

  ddr3_inport_responder #(
    .ADDR_W(AW), .ACK_LATENCY(LAT), .REFRESH_PERIOD(RP), .REFRESH_CYCLES(RC)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .inport_wr_i(inport_wr_i), .inport_rd_i(inport_rd_i), .inport_addr_i(inport_addr_i),
    .inport_write_data_i(inport_write_data_i), .inport_req_id_i(inport_req_id_i),
    .inport_accept_o(inport_accept_o), .inport_ack_o(inport_ack_o), .inport_error_o(inport_error_o),
    .inport_resp_id_o(inport_resp_id_o), .inport_read_data_o(inport_read_data_o)
  );

  int vectors = 0;
  int miscompares = 0;
  int pc;

  // Rising edges seen since reset release; at a falling edge this is the cycle number.
  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) pc <= 0;
    else       pc <= pc + 1;
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, pc, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: bound expired at cycle %0d", name, pc);
  endtask

  // Reference model: request windows, refresh windows and a plain memory array.
  logic [127:0] mdl_mem [2**AW];
  bit           pend;
  int           ref_end, busy_end, ack_cyc;
  bit           e_err;
  logic [15:0]  e_id, last_id;
  logic [127:0] e_data, last_data;

  always @(negedge clk_i) begin
    int  n;
    bit  exp_acc, exp_ack, valid, err;
    int  line;
    if (rst_i) begin
      pend = 0; ref_end = 0; busy_end = -1; ack_cyc = -1;
      last_id = '0; last_data = '0;
    end else begin
      n = pc;
      if (n == ref_end) pend = 0;
      if (n > 0 && n % RP == 0) pend = 1;
      if (n < ref_end || n <= busy_end) exp_acc = 0;
      else if (pend) begin
        ref_end = n + RC;
        exp_acc = 0;
      end else exp_acc = 1;
      chk("accept", {127'd0, inport_accept_o}, {127'd0, exp_acc});

      exp_ack = (n == ack_cyc);
      chk("ack", {127'd0, inport_ack_o}, {127'd0, exp_ack});
      chk("error", {127'd0, inport_error_o}, {127'd0, exp_ack ? e_err : 1'b0});
      if (exp_ack) begin
        last_id = e_id;
        last_data = e_data;
      end
      chk("resp_id", {112'd0, inport_resp_id_o}, {112'd0, last_id});
      chk("read_data", inport_read_data_o, last_data);

      valid = (inport_wr_i != 0) || inport_rd_i;
      if (exp_acc && valid) begin
        err  = ((inport_wr_i != 0) && inport_rd_i) || ((inport_addr_i >> (AW + 4)) != 0);
        line = int'((inport_addr_i >> 4) % (2**AW));
        if (!err && inport_wr_i != 0)
          for (int b = 0; b < 16; b++)
            if (inport_wr_i[b]) mdl_mem[line][8*b +: 8] = inport_write_data_i[8*b +: 8];
        e_err    = err;
        e_id     = inport_req_id_i;
        e_data   = (!err && inport_rd_i) ? mdl_mem[line] : '0;
        ack_cyc  = n + LAT;
        busy_end = n + LAT;
      end
    end
  end

  task automatic drive(input logic [15:0] wr, input logic rd, input logic [31:0] addr,
                       input logic [127:0] data, input logic [15:0] id);
    inport_wr_i = wr; inport_rd_i = rd; inport_addr_i = addr;
    inport_write_data_i = data; inport_req_id_i = id;
  endtask

  task automatic idle_inputs();
    inport_wr_i = '0; inport_rd_i = 1'b0;
    inport_addr_i = $urandom; inport_write_data_i = {4{$urandom}};
  endtask

  task automatic wait_accept(output int low);
    low = 0;
    forever begin
      @(negedge clk_i);
      if (inport_accept_o) break;
      low++;
      if (low > 200) begin timeout("wait_accept"); break; end
    end
    @(posedge clk_i); #1;
  endtask

  task automatic wait_ack(output int lat, output logic err, output logic [15:0] id, output logic [127:0] data);
    lat = 0; err = 1'b0; id = '0; data = '0;
    forever begin
      @(negedge clk_i);
      lat++;
      if (inport_ack_o) begin
        err = inport_error_o; id = inport_resp_id_o; data = inport_read_data_o;
        break;
      end
      if (lat > 300) begin timeout("wait_ack"); break; end
    end
  endtask

  task automatic xact(input logic [15:0] wr, input logic rd, input logic [31:0] addr,
                      input logic [127:0] data, input logic [15:0] id,
                      output int lat, output logic err, output logic [15:0] rid, output logic [127:0] rdata);
    int low;
    @(posedge clk_i); #1;
    drive(wr, rd, addr, data, id);
    wait_accept(low);
    idle_inputs();
    wait_ack(lat, err, rid, rdata);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, low, acks;
    logic err;
    logic [15:0] rid;
    logic [127:0] rdata;
    localparam logic [127:0] D35 = 128'hffeeddccbbaa99887766554433221100;
    localparam logic [127:0] D36 = 128'hbeaffeadd0d0600d5555AAAA00000000;

    repeat (3) @(negedge clk_i);
    chk("rst_accept", {127'd0, inport_accept_o}, 128'd1);
    chk("rst_ack", {127'd0, inport_ack_o}, 128'd0);
    chk("rst_error", {127'd0, inport_error_o}, 128'd0);
    chk("rst_resp_id", {112'd0, inport_resp_id_o}, 128'd0);
    chk("rst_read_data", inport_read_data_o, 128'd0);
    @(posedge clk_i); #1 rst_i = 1'b0;

    for (int l = 0; l < 2**AW; l++)
      xact(16'hFFFF, 1'b0, 32'(l) << 4, {$urandom, $urandom, $urandom, $urandom}, 16'(l), lat, err, rid, rdata);

    xact(16'hFFFF, 1'b0, 32'h0, D35, 16'h0035, lat, err, rid, rdata);
    xact(16'h0000, 1'b1, 32'h0, '0, 16'h0135, lat, err, rid, rdata);
    chk("r35_data", rdata, D35);
    chk("r35_latency", 128'(lat), 128'd4);
    chk("r35_error", {127'd0, err}, 128'd0);

    xact(16'hFFFF, 1'b0, 32'd16, 128'hbeaffeadd0d0600d5555AAAA13572468, 16'h0036, lat, err, rid, rdata);
    xact(16'h000F, 1'b0, 32'd16, '0, 16'h0136, lat, err, rid, rdata);
    chk("w36_write_data_zero", rdata, 128'd0);
    xact(16'h0000, 1'b1, 32'd16, '0, 16'h0236, lat, err, rid, rdata);
    chk("r36_data", rdata, D36);

    xact(16'hFFFF, 1'b1, 32'h0, {4{32'h0BAD0BAD}}, 16'h0007, lat, err, rid, rdata);
    chk("e37_error", {127'd0, err}, 128'd1);
    chk("e37_resp_id", {112'd0, rid}, 128'h7);
    chk("e37_data", rdata, 128'd0);
    xact(16'h0000, 1'b1, 32'h0, '0, 16'h0137, lat, err, rid, rdata);
    chk("e37_mem_unchanged", rdata, D35);
    xact(16'h0000, 1'b1, 32'h0001_0000, '0, 16'h0237, lat, err, rid, rdata);
    chk("e37_high_addr_error", {127'd0, err}, 128'd1);

    do @(negedge clk_i); while ((pc % RP) != RP - 1);
    @(posedge clk_i); #1;
    drive(16'h0000, 1'b1, 32'h0, '0, 16'h0038);
    wait_accept(low);
    idle_inputs();
    chk("refresh_accept_low", 128'(low), 128'd16);
    wait_ack(lat, err, rid, rdata);
    chk("refresh_resp_id", {112'd0, rid}, 128'h38);

    @(posedge clk_i); #1;
    drive(16'h0000, 1'b1, 32'h50, '0, 16'h0039);
    wait_accept(low);
    idle_inputs();
    @(posedge clk_i); #1 rst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
    acks = 0;
    repeat (20) begin
      @(negedge clk_i);
      if (inport_ack_o) acks++;
    end
    chk("abort_no_ack", 128'(acks), 128'd0);
    xact(16'h0000, 1'b1, 32'h0, '0, 16'h0139, lat, err, rid, rdata);
    chk("post_reset_latency", 128'(lat), 128'd4);
    chk("post_reset_resp_id", {112'd0, rid}, 128'h139);
    chk("post_reset_data", rdata, D35);

    @(posedge clk_i); #1;
    drive(16'h0000, 1'b1, 32'h30, '0, 16'd1);
    for (int k = 1; k <= 3; k++) begin
      wait_accept(low);
      if (k < 3) drive(16'h0000, 1'b1, 32'h30, '0, 16'(k + 1));
      else       idle_inputs();
      wait_ack(lat, err, rid, rdata);
      chk("b2b_order", {112'd0, rid}, 128'(k));
    end

    for (int i = 0; i < 200; i++) begin
      logic [31:0] a;
      logic [15:0] m;
      a = 32'($urandom_range(0, 2**AW - 1)) << 4 | 32'($urandom_range(0, 15));
      m = 16'($urandom_range(1, 16'hFFFF));
      case ($urandom_range(0, 5))
        0, 1: xact('0, 1'b1, a, {4{$urandom}}, 16'($urandom), lat, err, rid, rdata);
        2, 3: xact(m, 1'b0, a, {$urandom, $urandom, $urandom, $urandom}, 16'($urandom), lat, err, rid, rdata);
        4:    xact(m, 1'b1, a, {4{$urandom}}, 16'($urandom), lat, err, rid, rdata);
        default: xact('0, 1'b1, a | (32'($urandom_range(1, 16'hFFFF)) << 16), '0, 16'($urandom), lat, err, rid, rdata);
      endcase
      repeat ($urandom_range(0, 3)) @(posedge clk_i);
    end

    repeat (5) @(negedge clk_i);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
